// File: rtl/opi_phy_pkg.sv
// Shared types and constants for the OPI PHY transmit path.
package opi_phy_pkg;

  localparam int unsigned LEN_W    = 8;
  localparam int unsigned DUMMY_W  = 5;
  localparam int unsigned CNT_W    = LEN_W;
  localparam int unsigned SLOT_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WDATA,
    RDATA,
    HOLD
  } state_t;

  typedef struct packed {
    logic [15:0]        cmd;
    logic [31:0]        addr;
    logic               is_write;
    logic [LEN_W-1:0]   len;
    logic [DUMMY_W-1:0] dummy;
  } req_t;

  // State entered once the address/dummy phases are finished.
  function automatic state_t data_state(input req_t r);
    if (r.len == '0) return HOLD;
    return r.is_write ? WDATA : RDATA;
  endfunction

endpackage

// File: rtl/opi_slot_cnt.sv
// Loadable slot down-counter with a per-slot cycle phase.
module opi_slot_cnt
  import opi_phy_pkg::*;
(
  input  logic             clkin,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase0,
  output logic             slot_end,
  output logic             last_slot
);

  localparam int unsigned PH_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] cnt;

  // Count saturates at zero; a load always restarts at the first cycle of a slot.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      phase <= '0;
      cnt   <= '0;
    end else if (load) begin
      phase <= '0;
      cnt   <= load_val;
    end else if (run) begin
      if (slot_end) begin
        phase <= '0;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end else begin
        phase <= phase + PH_W'(1);
      end
    end else begin
      phase <= '0;
    end
  end

  assign phase0    = (phase == '0);
  assign slot_end  = (phase == PH_W'(SLOT_CYC - 1));
  assign last_slot = (cnt <= CNT_W'(1));

endmodule

// File: rtl/opi_tx_framer.sv
// OPI transmit framer: sequences cmd/addr/dummy/data slots into gear_32b_8b.
// Define OPI_TX_CMD_INV_EN to send {cmd[7:0], ~cmd[7:0]} in the command slot.
module opi_tx_framer
  import opi_phy_pkg::*;
#(
  parameter int unsigned CS_HOLD = 2
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [15:0]        req_cmd,
  input  logic [31:0]        req_addr,
  input  logic               req_is_write,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [DUMMY_W-1:0] req_dummy,
  input  logic [31:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               strobe,
  output logic               lo16b,
  output logic [31:0]        din,
  output logic               oe,
  output logic               cs_n,
  output logic               busy,
  output logic               err_underrun
);

  state_t           state, state_nxt, succ;
  req_t             req, req_nxt;
  logic             load, run, phase0, slot_end, last_slot;
  logic [CNT_W-1:0] load_val;
  logic             accept, take, first_nxt, drive_nxt;
  logic             req_ready_nxt, wr_ready_nxt, strobe_nxt, lo16b_nxt;
  logic             oe_nxt, cs_n_nxt, busy_nxt, err_nxt;
  logic [31:0]      din_nxt;

  assign run = (state != IDLE);

  opi_slot_cnt u_slot_cnt (
    .clkin     (clkin),
    .reset     (reset),
    .load      (load),
    .run       (run),
    .load_val  (load_val),
    .phase0    (phase0),
    .slot_end  (slot_end),
    .last_slot (last_slot)
  );

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req          <= '0;
      req_ready    <= 1'b1;
      wr_ready     <= 1'b0;
      strobe       <= 1'b0;
      lo16b        <= 1'b0;
      din          <= '0;
      oe           <= 1'b0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      req          <= req_nxt;
      req_ready    <= req_ready_nxt;
      wr_ready     <= wr_ready_nxt;
      strobe       <= strobe_nxt;
      lo16b        <= lo16b_nxt;
      din          <= din_nxt;
      oe           <= oe_nxt;
      cs_n         <= cs_n_nxt;
      busy         <= busy_nxt;
      err_underrun <= err_nxt;
    end
  end

  // Outputs are computed for the upcoming cycle so they leave a flop aligned with the state.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    succ      = state;
    load      = 1'b0;
    load_val  = '0;
    din_nxt   = '0;
    accept    = (state == IDLE) && req_valid && req_ready;
    take      = wr_ready && wr_valid;
    err_nxt   = accept ? 1'b0 : err_underrun;

    case (state)
      IDLE:          succ = CMD;
      CMD:           succ = ADDR;
      ADDR:          succ = (req.dummy != '0) ? DUMMY : data_state(req);
      DUMMY:         succ = last_slot ? data_state(req) : DUMMY;
      WDATA, RDATA:  succ = last_slot ? HOLD : state;
      HOLD:          succ = last_slot ? IDLE : HOLD;
      default:       succ = IDLE;
    endcase

    if (accept) begin
      state_nxt        = CMD;
      req_nxt.cmd      = req_cmd;
      req_nxt.addr     = req_addr;
      req_nxt.is_write = req_is_write;
      req_nxt.len      = req_len;
      req_nxt.dummy    = req_dummy;
    end else if (run && slot_end) begin
      state_nxt = succ;
    end

    first_nxt = accept || (run && slot_end && succ != IDLE);
    load      = first_nxt && (accept || succ != state);
    case (state_nxt)
      CMD, ADDR:    load_val = CNT_W'(1);
      DUMMY:        load_val = CNT_W'(req_nxt.dummy);
      WDATA, RDATA: load_val = req_nxt.len;
      HOLD:         load_val = CNT_W'(CS_HOLD);
      default:      load_val = '0;
    endcase

    drive_nxt     = state_nxt inside {CMD, ADDR, WDATA};
    strobe_nxt    = first_nxt && drive_nxt;
    lo16b_nxt     = (state_nxt == CMD);
    oe_nxt        = drive_nxt;
    cs_n_nxt      = state_nxt inside {IDLE, HOLD};
    busy_nxt      = (state_nxt != IDLE);
    req_ready_nxt = (state_nxt == IDLE);
    wr_ready_nxt  = phase0 && run && (succ == WDATA);

    if (drive_nxt) din_nxt = din;
    if (first_nxt) begin
      case (state_nxt)
`ifdef OPI_TX_CMD_INV_EN
        CMD:   din_nxt = {16'h0, req_nxt.cmd[7:0], ~req_nxt.cmd[7:0]};
`else
        CMD:   din_nxt = {16'h0, req_nxt.cmd};
`endif
        ADDR:  din_nxt = req.addr;
        WDATA: begin
          din_nxt = take ? wr_data : 32'h0;
          if (!take) err_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
